// File: rtl/miter_chk_pkg.sv
// rtl/miter_chk_pkg.sv - shared state type and masked compare helper for the miter stream checker
package miter_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_e;

  // Widest token the compare helper accepts; callers zero-extend narrower tokens.
  localparam int MAX_W = 64;

  function automatic logic is_mismatch(input logic [MAX_W-1:0] gold,
                                       input logic [MAX_W-1:0] gate,
                                       input logic [MAX_W-1:0] dc);
    return |((gold ^ gate) & ~dc);
  endfunction

endpackage

// File: rtl/miter_tok_fifo.sv
// rtl/miter_tok_fifo.sv - show-ahead token FIFO with wrap-bit pointers and synchronous flush
module miter_tok_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/miter_stream_checker.sv
// rtl/miter_stream_checker.sv - aligns gold/gate token streams, masked compare, counts and first-failure capture
module miter_stream_checker import miter_chk_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             gold_vld,
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] gold_dc,
  input  logic             gate_vld,
  input  logic [WIDTH-1:0] gate,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             overflow,
  output logic             orphan,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic [WIDTH-1:0] first_gold,
  output logic [WIDTH-1:0] first_gate
);

  chk_state_e         state;
  logic [2*WIDTH-1:0] g_dout;
  logic [WIDTH-1:0]   t_dout;
  logic [WIDTH-1:0]   g_val;
  logic [WIDTH-1:0]   g_dc;
  logic               g_empty, g_full, t_empty, t_full;
  logic               clr, push_g, push_t, cmp, ovf_ev;
  logic               cmp_q, mis_q;
  logic [WIDTH-1:0]   res_gold, res_gate;

  assign clr    = start && (state == IDLE || state == DONE);
  assign push_g = (state == RUN) && gold_vld;
  assign push_t = (state == RUN) && gate_vld;
  assign cmp    = busy && !g_empty && !t_empty;
  assign ovf_ev = (push_g && g_full && !cmp) || (push_t && t_full && !cmp);
  assign g_val  = g_dout[WIDTH-1:0];
  assign g_dc   = g_dout[2*WIDTH-1:WIDTH];
  assign pass   = done && (mis_cnt == '0) && !overflow && !orphan;

  miter_tok_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_gold_fifo (
    .clk(clk), .rst_n(rst_n), .flush(clr), .push(push_g), .din({gold_dc, gold}),
    .pop(cmp), .dout(g_dout), .empty(g_empty), .full(g_full)
  );

  miter_tok_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_gate_fifo (
    .clk(clk), .rst_n(rst_n), .flush(clr), .push(push_t), .din(gate),
    .pop(cmp), .dout(t_dout), .empty(t_empty), .full(t_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      orphan   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          done     <= 1'b0;
          overflow <= 1'b0;
          orphan   <= 1'b0;
        end
        RUN: if (ovf_ev) begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          overflow <= 1'b1;
        end else if (stop) begin
          state <= DRAIN;
        end
        // No pair can form once either side runs dry; a leftover on the other side is an orphan.
        DRAIN: if (g_empty || t_empty) begin
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          orphan <= (g_empty != t_empty);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q      <= 1'b0;
      mis_q      <= 1'b0;
      res_gold   <= '0;
      res_gate   <= '0;
      tok_cnt    <= '0;
      mis_cnt    <= '0;
      first_idx  <= '0;
      first_gold <= '0;
      first_gate <= '0;
    end else if (clr) begin
      cmp_q      <= 1'b0;
      mis_q      <= 1'b0;
      res_gold   <= '0;
      res_gate   <= '0;
      tok_cnt    <= '0;
      mis_cnt    <= '0;
      first_idx  <= '0;
      first_gold <= '0;
      first_gate <= '0;
    end else begin
      cmp_q    <= cmp;
      mis_q    <= is_mismatch(MAX_W'(g_val), MAX_W'(t_dout), MAX_W'(g_dc));
      res_gold <= g_val;
      res_gate <= t_dout;
      if (cmp_q) begin
        if (tok_cnt != '1) tok_cnt <= tok_cnt + 1'b1;
        if (mis_q) begin
          if (mis_cnt != '1) mis_cnt <= mis_cnt + 1'b1;
          if (mis_cnt == '0) begin
            first_idx  <= tok_cnt;
            first_gold <= res_gold;
            first_gate <= res_gate;
          end
        end
      end
    end
  end

endmodule
